// File: rtl/des_pkg.sv
// =============================================================================
//  Module      : des_pkg
//  Description : Shared DES key-schedule tables, widths, FSM encoding and helpers.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 56;
    localparam int SK_W  = 48;

    localparam logic [15:0] SHIFT_SCHED_DEF = 16'h3F7E;

    // Entries use DES 1-based bit numbering of the source vector.
    localparam int unsigned PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_t;

    function automatic int sched_sum(input logic [31:0] sched, input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s = s + (sched[i] ? 2 : 1);
        end
        return s;
    endfunction

    // Bit 27 is DES bit 1 of the half, so "left" moves bits toward the MSB.
    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc1.sv
// =============================================================================
//  Module      : des_pc1
//  Description : DES permuted choice 1, 64-bit key to 56-bit {C0,D0}.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module des_pc1
    import des_pkg::*;
(
    input  logic [1:KEY_W] i_key,
    output logic [1:CD_W]  o_cd
);

    for (genvar i = 1; i <= CD_W; i++) begin : g_pc1
        assign o_cd[i] = i_key[PC1_TAB[i-1]];
    end

endmodule

`default_nettype wire

// File: rtl/des_pc2.sv
// =============================================================================
//  Module      : des_pc2
//  Description : DES permuted choice 2, 56-bit {C,D} to 48-bit round subkey.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module des_pc2
    import des_pkg::*;
(
    input  logic [1:CD_W] i_cd,
    output logic [1:SK_W] o_sk
);

    for (genvar i = 1; i <= SK_W; i++) begin : g_pc2
        assign o_sk[i] = i_cd[PC2_TAB[i-1]];
    end

endmodule

`default_nettype wire

// File: rtl/des_key_sched.sv
// =============================================================================
//  Module      : des_key_sched
//  Description : Sequential DES key schedule, one subkey per handshake beat,
//                encrypt or decrypt order, with per-byte odd-parity check.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module des_key_sched
    import des_pkg::*;
#(
    parameter int                    NUM_ROUNDS  = 16,
    parameter logic [NUM_ROUNDS-1:0] SHIFT_SCHED = SHIFT_SCHED_DEF,
    parameter bit                    PARITY_CHK  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:KEY_W]  key,
    input  logic            key_decrypt,
    input  logic            key_valid,
    output logic            key_ready,
    output logic [1:SK_W]   subkey,
    output logic [4:0]      sk_round,
    output logic            sk_valid,
    input  logic            sk_ready,
    output logic            done,
    output logic            key_par_err
);

    localparam int c_SHIFT_SUM = sched_sum(32'(SHIFT_SCHED), NUM_ROUNDS);

    if (c_SHIFT_SUM != 28) begin : g_bad_sched
        $error("des_key_sched: SHIFT_SCHED rotations sum to %0d, must be 28", c_SHIFT_SUM);
    end

    ks_state_t   r_state, w_state_nxt;
    logic [27:0] r_c, r_d;
    logic [4:0]  r_cnt;
    logic        r_mode, r_done, r_par_err;
    logic [1:CD_W] w_cd0, w_cd;
    logic        w_accept, w_beat, w_last;
    logic        w_two_enc, w_two_dec, w_par_err;

    des_pc1 u_pc1 (
        .i_key (key),
        .o_cd  (w_cd0)
    );

    assign w_cd = {r_c, r_d};

    des_pc2 u_pc2 (
        .i_cd (w_cd),
        .o_sk (subkey)
    );

    assign w_accept    = key_valid && key_ready;
    assign w_beat      = sk_valid && sk_ready;
    assign w_last      = (r_cnt == 5'(NUM_ROUNDS));
    assign done        = r_done;
    assign key_par_err = r_par_err;
    assign sk_round    = (r_state == ST_RUN) ? (r_mode ? 5'(NUM_ROUNDS + 1) - r_cnt : r_cnt) : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        key_ready   = 1'b0;
        sk_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                sk_valid = 1'b1;
                if (sk_ready && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Encrypt steps into round cnt+1; decrypt undoes round NUM_ROUNDS+1-cnt.
    always_comb begin
        w_two_enc = 1'b0;
        w_two_dec = 1'b0;
        for (int r = 1; r <= NUM_ROUNDS; r++) begin
            if (r_cnt + 5'd1 == 5'(r)) begin
                w_two_enc = SHIFT_SCHED[NUM_ROUNDS-r];
            end
            if (r_cnt == 5'(NUM_ROUNDS + 1 - r)) begin
                w_two_dec = SHIFT_SCHED[NUM_ROUNDS-r];
            end
        end
    end

    always_comb begin
        w_par_err = 1'b0;
        if (PARITY_CHK) begin
            for (int i = 0; i < 8; i++) begin
                if (~^key[8*i+1 +: 8]) begin
                    w_par_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_done <= w_beat && w_last;
            if (w_accept) begin
                r_mode    <= key_decrypt;
                r_cnt     <= 5'd1;
                r_par_err <= w_par_err;
                // Full rotation sums to 28, so unrotated C0/D0 is already C16/D16.
                if (key_decrypt) begin
                    r_c <= w_cd0[1:28];
                    r_d <= w_cd0[29:56];
                end else begin
                    r_c <= rotl28(w_cd0[1:28], SHIFT_SCHED[NUM_ROUNDS-1]);
                    r_d <= rotl28(w_cd0[29:56], SHIFT_SCHED[NUM_ROUNDS-1]);
                end
            end else if (w_beat && !w_last) begin
                r_cnt <= r_cnt + 5'd1;
                if (r_mode) begin
                    r_c <= rotr28(r_c, w_two_dec);
                    r_d <= rotr28(r_d, w_two_dec);
                end else begin
                    r_c <= rotl28(r_c, w_two_enc);
                    r_d <= rotl28(r_d, w_two_enc);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_des_key_sched.sv
// =============================================================================
//  Module      : tb_des_key_sched
//  Description : Self-checking bench for des_key_sched against a behavioural
//                DES key-schedule model plus hand-computed vectors.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_des_key_sched;

    localparam logic [63:0] c_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] c_KEYP = 64'h133457799BBCDFF0;
    localparam logic [47:0] c_K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] c_K16  = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk, rst;
    logic [1:64] key;
    logic        key_decrypt, key_valid, key_ready;
    logic [1:48] subkey;
    logic [4:0]  sk_round;
    logic        sk_valid, sk_ready, done, key_par_err;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [47:0] sk;
        logic [4:0]  rnd;
    } exp_t;
    exp_t q[$];

    des_key_sched dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_decrypt (key_decrypt),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .subkey      (subkey),
        .sk_round    (sk_round),
        .sk_valid    (sk_valid),
        .sk_ready    (sk_ready),
        .done        (done),
        .key_par_err (key_par_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DES bit j of a 64-bit key is k[64-j]; each round's C/D is C0/D0 rotated
    // by the cumulative shift count.
    function automatic logic [47:0] model_sk(input logic [63:0] k, input int round);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] sk;
        int tot;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1_T[i]];
            d[27-i] = k[64-PC1_T[28+i]];
        end
        tot = 0;
        for (int r = 0; r < round; r++) tot += SH[r];
        tot = tot % 28;
        if (tot != 0) begin
            c = (c << tot) | (c >> (28 - tot));
            d = (d << tot) | (d >> (28 - tot));
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) sk[47-i] = cd[56-PC2_T[i]];
        return sk;
    endfunction

    function automatic bit model_par(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model queue, sampled on the falling edge.
    initial begin
        bit          post_rst, exp_done, exp_par, prev_stall;
        logic [47:0] prev_sk;
        logic [4:0]  prev_rnd;
        exp_t        e;
        post_rst = 0; exp_done = 0; exp_par = 0; prev_stall = 0;
        prev_sk = '0; prev_rnd = '0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            if (post_rst) begin
                check("rst_sk_valid", 64'(sk_valid), 64'd0);
                check("rst_key_ready", 64'(key_ready), 64'd1);
                check("rst_subkey", 64'(subkey), 64'd0);
                check("rst_sk_round", 64'(sk_round), 64'd0);
                post_rst = 0;
            end
            check("done", 64'(done), 64'(exp_done));
            check("key_par_err", 64'(key_par_err), 64'(exp_par));
            check("ready_vs_valid", 64'(key_ready), 64'(!sk_valid));
            if (prev_stall) begin
                check("stall_valid", 64'(sk_valid), 64'd1);
                check("stall_subkey", 64'(subkey), 64'(prev_sk));
                check("stall_round", 64'(sk_round), 64'(prev_rnd));
            end
            if (sk_valid) begin
                if (q.size() == 0) begin
                    check("extra_beat_qsize", 64'd0, 64'd1);
                end else begin
                    check("model_subkey", 64'(subkey), 64'(q[0].sk));
                    check("model_round", 64'(sk_round), 64'(q[0].rnd));
                end
            end
            if (rst) begin
                q.delete();
                exp_done = 0; exp_par = 0; prev_stall = 0; post_rst = 1;
            end else begin
                exp_done = 0;
                if (sk_valid && sk_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) exp_done = 1;
                end
                prev_stall = sk_valid && !sk_ready;
                prev_sk = subkey;
                prev_rnd = sk_round;
                if (key_valid && key_ready) begin
                    check("accept_q_empty", 64'(q.size()), 64'd0);
                    for (int i = 1; i <= 16; i++) begin
                        e.rnd = key_decrypt ? 5'(17 - i) : 5'(i);
                        e.sk  = model_sk(key, int'(e.rnd));
                        q.push_back(e);
                    end
                    exp_par = model_par(key);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            sk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_ready && n < 100);
        check(name, 64'(key_ready), 64'd1);
    endtask

    task automatic send_key(input logic [63:0] k, input logic dec);
        @(posedge clk);
        #1;
        key = k;
        key_decrypt = dec;
        key_valid = 1'b1;
        wait_ready("send_key_ready");
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; key = '0; key_decrypt = 1'b0; key_valid = 1'b0; sk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("model_pin_k1", 64'(model_sk(c_KEY, 1)), 64'(c_K1));
        check("model_pin_k16", 64'(model_sk(c_KEY, 16)), 64'(c_K16));
        check("model_pin_par", 64'(model_par(c_KEYP)), 64'd1);

        // Encrypt, always ready
        send_key(c_KEY, 1'b0);
        @(negedge clk);
        check("enc_first_sk", 64'(subkey), 64'(c_K1));
        check("enc_first_rnd", 64'(sk_round), 64'd1);
        repeat (15) @(negedge clk);
        check("enc_last_sk", 64'(subkey), 64'(c_K16));
        check("enc_last_rnd", 64'(sk_round), 64'd16);
        @(negedge clk);
        check("enc_done", 64'(done), 64'd1);
        check("enc_key_ready", 64'(key_ready), 64'd1);
        check("enc_par_err", 64'(key_par_err), 64'd0);

        // Decrypt
        send_key(c_KEY, 1'b1);
        @(negedge clk);
        check("dec_first_sk", 64'(subkey), 64'(c_K16));
        check("dec_first_rnd", 64'(sk_round), 64'd16);
        repeat (15) @(negedge clk);
        check("dec_last_sk", 64'(subkey), 64'(c_K1));
        check("dec_last_rnd", 64'(sk_round), 64'd1);
        @(negedge clk);
        check("dec_done", 64'(done), 64'd1);

        // Random back-pressure
        rand_ready = 1'b1;
        send_key(c_KEY, 1'b0);
        wait_done("stall_done");
        rand_ready = 1'b0;

        // Bad parity in last byte
        send_key(c_KEYP, 1'b0);
        @(negedge clk);
        check("par_err_set", 64'(key_par_err), 64'd1);
        check("par_first_sk", 64'(subkey), 64'(c_K1));
        wait_done("par_done");

        // Reset in place of beat 7
        send_key(c_KEY, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(sk_valid), 64'd0);
        check("mid_rst_subkey", 64'(subkey), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        check("mid_rst_no_done", 64'(done), 64'd0);
        send_key(c_KEY, 1'b0);
        wait_done("post_rst_done");

        // Back-to-back offer: zero key, then all-ones held through the run
        @(posedge clk);
        #1;
        key = '0;
        key_decrypt = 1'b0;
        key_valid = 1'b1;
        wait_ready("b2b_a_ready");
        @(posedge clk);
        #1 key = '1;
        @(negedge clk);
        check("zero_key_sk", 64'(subkey), 64'd0);
        check("zero_key_valid", 64'(sk_valid), 64'd1);
        wait_ready("b2b_b_ready");
        check("b2b_b_on_done", 64'(done), 64'd1);
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        check("ones_key_sk", 64'(subkey), 64'hFFFF_FFFF_FFFF);
        wait_done("b2b_done");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
